// File: rtl/maxpool_1d_stream_if.sv
// Stream bundle around the pooling stage: input samples from the conv engine
// and pooled results to the next layer, each with a valid/ready handshake.
interface maxpool_1d_stream_if #(
  parameter int W = 16
);
  logic signed [W-1:0] x_data;
  logic                x_valid;
  logic                x_ready;
  logic signed [W-1:0] y_data;
  logic                y_valid;
  logic                y_ready;
  logic                y_last;

  // slave is the pooling block; master is whatever surrounds it
  modport slave (
    input  x_data, x_valid, y_ready,
    output x_ready, y_data, y_valid, y_last
  );

  modport master (
    output x_data, x_valid, y_ready,
    input  x_ready, y_data, y_valid, y_last
  );
endinterface

// File: rtl/maxpool_1d_stream.sv
// Streaming 1-D max pooling: reduces each non-overlapping window of P signed
// samples to its maximum, N samples per frame, last value of a frame tagged.
module maxpool_1d_stream #(
  parameter int N = 23,
  parameter int P = 2,
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  maxpool_1d_stream_if.slave   bus
);

  localparam int WC_W = (P > 1) ? $clog2(P) : 1;
  localparam int FC_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [WC_W-1:0] WIN_LAST = WC_W'(P - 1);
  localparam logic [FC_W-1:0] FRM_LAST = FC_W'(N - 1);

  logic [WC_W-1:0]     win_cnt_q, win_cnt_d;
  logic [FC_W-1:0]     frm_cnt_q, frm_cnt_d;
  logic signed [W-1:0] cur_max_q, cur_max_d;
  logic signed [W-1:0] y_data_q,  y_data_d;
  logic                y_valid_q, y_valid_d;
  logic                y_last_q,  y_last_d;

  logic                closing;
  logic                frm_end;
  logic                x_ready;
  logic                accept;
  logic signed [W-1:0] win_max;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    frm_end = (frm_cnt_q == FRM_LAST);
    closing = (win_cnt_q == WIN_LAST) | frm_end;
    // Only the closing sample needs room in the output register.
    x_ready = ~closing | ~y_valid_q | bus.y_ready;
    accept  = bus.x_valid & x_ready;

    if (win_cnt_q == '0) win_max = bus.x_data;
    else                 win_max = (bus.x_data > cur_max_q) ? bus.x_data : cur_max_q;

    win_cnt_d = win_cnt_q;
    frm_cnt_d = frm_cnt_q;
    cur_max_d = cur_max_q;
    y_data_d  = y_data_q;
    y_valid_d = y_valid_q;
    y_last_d  = y_last_q;

    if (y_valid_q & bus.y_ready) y_valid_d = 1'b0;

    if (accept) begin
      if (closing) begin
        y_data_d  = win_max;
        y_valid_d = 1'b1;
        y_last_d  = frm_end;
        win_cnt_d = '0;
        frm_cnt_d = frm_end ? '0 : frm_cnt_q + 1'b1;
      end else begin
        cur_max_d = win_max;
        win_cnt_d = win_cnt_q + 1'b1;
        frm_cnt_d = frm_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values computed above; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_q <= '0;
      frm_cnt_q <= '0;
      cur_max_q <= '0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
    end else begin
      win_cnt_q <= win_cnt_d;
      frm_cnt_q <= frm_cnt_d;
      cur_max_q <= cur_max_d;
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
      y_last_q  <= y_last_d;
    end
  end

  assign bus.x_ready = x_ready;
  assign bus.y_data  = y_data_q;
  assign bus.y_valid = y_valid_q;
  assign bus.y_last  = y_last_q;

endmodule
